// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - CPU register front end with TX/RX FIFOs for uart_core

// Circular FIFO; push is accepted when not full or when a pop frees a slot this cycle
module uart_fifo_bridge_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage array, no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

module uart_fifo_bridge #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [11:0] DIV_RESET  = 12'd103
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  addr,
   input  logic [7:0]  wdata,
   input  logic        wr,
   input  logic        rd,
   output logic [7:0]  rdata,
   output logic        irq,
   output logic [11:0] divider,
   output logic [7:0]  data_tx,
   output logic        have_data_tx,
   input  logic        transmitting,
   input  logic [7:0]  data_rx,
   input  logic        have_data_rx,
   output logic        data_rx_ack
);
   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_DIV_LO = 2'd2;
   localparam logic [1:0] A_DIV_HI = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_START, S_WAIT_DONE} tx_state_t;

   tx_state_t  state;
   tx_state_t  state_next;
   logic       tx_busy;
   logic       tx_empty;
   logic       tx_full;
   logic [7:0] tx_head;
   logic       tx_pop;
   logic       tx_push_ok;
   logic       rx_empty;
   logic       rx_full;
   logic [7:0] rx_head;
   logic       rx_pop;
   logic       rx_push_ok;
   logic       rx_capture;
   logic       ack_pending;
   logic       rx_ovr;
   logic       tx_ovf;
   logic       wr_data;
   logic       rd_data;
   logic       wr_status;
   logic [7:0] status;
   logic [7:0] rd_mux;

   assign wr_data   = wr && (addr == A_DATA);
   assign rd_data   = rd && (addr == A_DATA);
   assign wr_status = wr && (addr == A_STATUS);

   assign tx_pop     = (state == S_IDLE) && !tx_empty && !transmitting;
   assign tx_push_ok = wr_data && (!tx_full || tx_pop);

   assign rx_capture = have_data_rx && !ack_pending;
   assign rx_pop     = rd_data && !rx_empty;
   assign rx_push_ok = rx_capture && (!rx_full || rx_pop);

   assign data_rx_ack = ack_pending;
   assign status      = {2'b00, tx_ovf, rx_ovr, tx_busy, tx_empty, tx_full, !rx_empty};
   assign irq         = !rx_empty || rx_ovr || tx_ovf;

   uart_fifo_bridge_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (tx_push_ok),
      .push_data (wdata),
      .pop       (tx_pop),
      .head      (tx_head),
      .empty     (tx_empty),
      .full      (tx_full)
   );

   uart_fifo_bridge_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rx_push_ok),
      .push_data (data_rx),
      .pop       (rx_pop),
      .head      (rx_head),
      .empty     (rx_empty),
      .full      (rx_full)
   );

   // TX FSM state register and the byte latched for the core
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         data_tx <= 8'h00;
      end else begin
         state <= state_next;
         if (tx_pop) data_tx <= tx_head;
      end
   end

   // TX FSM next state; load pulse comes from LOAD so it can never overlap a frame
   always_comb begin
      state_next   = state;
      have_data_tx = 1'b0;
      tx_busy      = (state != S_IDLE);
      case (state)
         S_IDLE:       if (tx_pop) state_next = S_LOAD;
         S_LOAD: begin
            have_data_tx = 1'b1;
            state_next   = S_WAIT_START;
         end
         S_WAIT_START: if (transmitting) state_next = S_WAIT_DONE;
         S_WAIT_DONE:  if (!transmitting) state_next = S_IDLE;
         default:      state_next = S_IDLE;
      endcase
   end

   // RX ack handshake: one-cycle ack, pending bit blocks re-capture of a held byte
   always_ff @(posedge clk) begin
      if (!rst_n) ack_pending <= 1'b0;
      else        ack_pending <= rx_capture;
   end

   // sticky error flags; a set in the same cycle as a clear wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_ovr <= 1'b0;
         tx_ovf <= 1'b0;
      end else begin
         rx_ovr <= (rx_capture && !rx_push_ok) || (rx_ovr && !(wr_status && wdata[4]));
         tx_ovf <= (wr_data && !tx_push_ok)    || (tx_ovf && !(wr_status && wdata[5]));
      end
   end

   // baud divider register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         divider <= DIV_RESET;
      end else if (wr) begin
         if (addr == A_DIV_LO) divider[7:0]  <= wdata;
         if (addr == A_DIV_HI) divider[11:8] <= wdata[3:0];
      end
   end

   // read mux built from pre-write register state
   always_comb begin
      rd_mux = 8'h00;
      case (addr)
         A_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
         A_STATUS: rd_mux = status;
         A_DIV_LO: rd_mux = divider[7:0];
         A_DIV_HI: rd_mux = {4'h0, divider[11:8]};
         default:  rd_mux = 8'h00;
      endcase
   end

   // read data register, held between reads
   always_ff @(posedge clk) begin
      if (!rst_n)  rdata <= 8'h00;
      else if (rd) rdata <= rd_mux;
   end
endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Bus-facing front end for uart_core: an 8-bit register interface driven by the CPU, with a TX FIFO feeding the core's data_tx/have_data_tx handshake and an RX FIFO draining data_rx/have_data_rx/data_rx_ack.
- Owns the 12-bit baud divider register and the sticky error flags.
- Sits between the CPU peripheral bus decode and uart_core.

Parameters:
- FIFO_DEPTH, 4, entries per FIFO; power of two, minimum 2.
- DIV_RESET, 12'd103, divider value loaded at reset.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous, active-low reset.
- addr  input  2  register select.
- wdata  input  8  bus write data.
- wr  input  1  one-cycle write strobe.
- rd  input  1  one-cycle read strobe.
- rdata  output  8  registered read data, valid the cycle after rd.
- irq  output  1  level: RX FIFO not empty OR any sticky error set.
- divider  output  12  to uart_core divider.
- data_tx  output  8  to uart_core.
- have_data_tx  output  1  to uart_core, single-cycle load pulse.
- transmitting  input  1  from uart_core.
- data_rx  input  8  from uart_core.
- have_data_rx  input  1  from uart_core.
- data_rx_ack  output  1  to uart_core, single-cycle.

Behaviour:
- Reset values:
  - rdata=0, have_data_tx=0, data_tx=0, data_rx_ack=0, irq=0.
  - divider=DIV_RESET; both FIFOs empty; sticky flags cleared; TX FSM in IDLE.
  - Reset mid-operation discards all FIFO contents and FSM state.
- Register map:
  - addr 0 DATA:
    - Write pushes wdata into the TX FIFO. If the FIFO is full, the write is dropped and tx_ovf is set.
    - Read pops the RX FIFO into rdata. If the FIFO is empty, rdata=0x00, no pop, no flag change.
  - addr 1 STATUS:
    - Read bits: [0] rx_nonempty, [1] tx_full, [2] tx_empty, [3] tx_busy (FSM not IDLE), [4] rx_ovr, [5] tx_ovf, [7:6]=0.
    - Write 1 to bit4/bit5 clears that flag. A clear and a set in the same cycle leave the flag set.
  - addr 2 DIV_LO: R/W divider[7:0].
  - addr 3 DIV_HI: R/W divider[11:8] in wdata[3:0]; reads return [7:4]=0.
- Bus timing:
  - rd and wr asserted together: the write takes effect and the read returns pre-write register state.
  - rdata holds its value until the next rd.
- TX FSM (states IDLE, LOAD, WAIT_START, WAIT_DONE):
  - IDLE: if TX FIFO is non-empty and transmitting=0, pop head into data_tx, go to LOAD.
  - LOAD: have_data_tx=1 for exactly this cycle, then go to WAIT_START.
  - WAIT_START: wait for transmitting=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for transmitting=0, then go to IDLE.
  - Minimum spacing between have_data_tx pulses is the full core frame plus 2 cycles. No pulse is ever issued while transmitting=1.
  - A FIFO push and pop in the same cycle are both honoured; occupancy is unchanged.
- RX path:
  - When have_data_rx=1 and ack_pending=0, assert data_rx_ack for one cycle and set ack_pending. ack_pending clears on the following cycle.
  - ack_pending prevents a double capture while the core's have_data_rx is still high.
  - On capture, push data_rx if the RX FIFO is not full. If it is full, drop the byte, still ack, and set rx_ovr.
  - A CPU pop and a core push in the same cycle with the FIFO full: the pop frees a slot, the push succeeds, rx_ovr is not set.
- FIFOs:
  - Circular buffers with wrap-around read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Order is strictly FIFO.
- irq is combinational from registered state.

Test Plan:
- Reset: after rst_n low for 1 cycle, STATUS read returns 0x04 (tx_empty only), DIV_LO/DIV_HI return 0x67/0x00, irq=0.
- TX single byte: write 0x55 to DATA → have_data_tx high one cycle with data_tx=0x55; transmitting high one cycle after the pulse, low at frame end; tx_busy clears 1 cycle later.
- TX burst: write 0x01..0x05 with FIFO_DEPTH=4 → bytes 0x01..0x04 or 0x01..0x05 sent in order depending on pop timing; fifth write while full sets STATUS bit5; writing 0x20 to STATUS clears it.
- RX: core model raises have_data_rx with data_rx=0xA3 and holds it 2 cycles → exactly one ack pulse and one push; irq=1; DATA read returns 0xA3, next read returns 0x00; irq drops.
- RX overrun: push 5 bytes without reading → rx_ovr=1, the FIFO holds the first 4 in order, and the fifth byte is acked and dropped.
- Divider: write DIV_HI=0xF2, DIV_LO=0x0A → divider=12'h20A; read DIV_HI returns 0x02; combined loopback at divider=4 transmits and receives 0x3C correctly.
